// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, ALU, radix-2 iterative multiply/divide unit
// with HI/LO, and the EX/MEM pipeline register.
module ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_a,
  input  logic [31:0] data_b,
  input  logic [31:0] imm,
  input  logic [4:0]  shamt,
  input  logic        alusrc_b,
  input  logic        sh_var,
  input  logic [3:0]  alu_fun,
  input  logic [2:0]  md_op,
  input  logic        md_hi,
  input  logic [1:0]  fwd_a,
  input  logic [1:0]  fwd_b,
  input  logic [31:0] wb_data,
  input  logic [31:0] pc,
  input  logic        reg_wr,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [1:0]  mem2reg,
  input  logic [4:0]  addrc,
  input  logic        flush,
  output logic [31:0] alu_out,
  output logic [31:0] data_b0,
  output logic [31:0] pc_m,
  output logic        reg_wr_m,
  output logic        mem_rd_m,
  output logic        mem_wr_m,
  output logic [1:0]  mem2reg_m,
  output logic [4:0]  addrc_m,
  output logic        ex_stall,
  output logic        md_busy
);

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MFHI  = 3'd5;
  localparam logic [2:0] MD_MFLO  = 3'd6;
  localparam logic [2:0] MD_MT    = 3'd7;

  function automatic logic [31:0] fwd_sel(input logic [1:0] sel, input logic [31:0] id_val,
                                          input logic [31:0] ex_val, input logic [31:0] wb_val);
    case (sel)
      2'd0:    return id_val;
      2'd1:    return ex_val;
      2'd2:    return wb_val;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  logic [31:0] op_a, fwd_b_val, op_b, alu_res, ex_res;
  logic signed [31:0] op_a_s, op_b_s;
  logic [4:0]  sh_amt;
  logic [31:0] hi, lo, hi_nxt, lo_nxt;
  logic [4:0]  md_cnt;
  logic [31:0] md_acc, md_q, md_opnd, md_dvd;
  logic        md_div, md_neg_q, md_neg_r;
  logic        md_start, md_done, md_sgn;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [31:0] step_acc, step_q;
  logic [63:0] prod;

  always_comb begin
    op_a      = fwd_sel(fwd_a, data_a, alu_out, wb_data);
    fwd_b_val = fwd_sel(fwd_b, data_b, alu_out, wb_data);
    op_b      = alusrc_b ? imm : fwd_b_val;
    sh_amt    = sh_var ? op_a[4:0] : shamt;
  end

  assign op_a_s   = op_a;
  assign op_b_s   = op_b;
  assign ex_stall = md_busy && (md_op != MD_NONE);
  assign md_start = !md_busy && !flush && (md_op >= MD_MULT) && (md_op <= MD_DIVU);
  assign md_sgn   = (md_op == MD_MULT) || (md_op == MD_DIV);
  assign md_done  = md_busy && (md_cnt == 5'd31);

  always_comb begin
    case (alu_fun)
      4'd0:    alu_res = op_a + op_b;
      4'd1:    alu_res = op_a - op_b;
      4'd2:    alu_res = op_a & op_b;
      4'd3:    alu_res = op_a | op_b;
      4'd4:    alu_res = op_a ^ op_b;
      4'd5:    alu_res = ~(op_a | op_b);
      4'd6:    alu_res = {31'd0, op_a_s < op_b_s};
      4'd7:    alu_res = {31'd0, op_a < op_b};
      4'd8:    alu_res = op_b << sh_amt;
      4'd9:    alu_res = op_b >> sh_amt;
      4'd10:   alu_res = op_b_s >>> sh_amt;
      4'd11:   alu_res = {op_b[15:0], 16'h0000};
      default: alu_res = 32'd0;
    endcase
  end

  // One radix-2 iteration on magnitudes: shift-add multiply or restoring divide.
  always_comb begin
    mul_sum   = {1'b0, md_acc} + (md_q[0] ? {1'b0, md_opnd} : 33'd0);
    div_shift = {md_acc, md_q[31]};
    div_diff  = div_shift - {1'b0, md_opnd};
    if (md_div) begin
      if (!div_diff[32]) begin
        step_acc = div_diff[31:0];
        step_q   = {md_q[30:0], 1'b1};
      end else begin
        step_acc = div_shift[31:0];
        step_q   = {md_q[30:0], 1'b0};
      end
    end else begin
      step_acc = mul_sum[32:1];
      step_q   = {mul_sum[0], md_q[31:1]};
    end
  end

  // HI/LO next value; MFHI/MFLO read this so a same-edge write is bypassed.
  always_comb begin
    prod   = {step_acc, step_q};
    if (md_neg_q) prod = -prod;
    hi_nxt = hi;
    lo_nxt = lo;
    if (md_done) begin
      if (!md_div) begin
        hi_nxt = prod[63:32];
        lo_nxt = prod[31:0];
      end else if (md_opnd == 32'd0) begin
        hi_nxt = md_dvd;
        lo_nxt = 32'hFFFF_FFFF;
      end else begin
        hi_nxt = neg_if(step_acc, md_neg_r);
        lo_nxt = neg_if(step_q, md_neg_q);
      end
    end else if (!md_busy && !flush && md_op == MD_MT) begin
      if (md_hi) hi_nxt = op_a;
      else       lo_nxt = op_a;
    end
  end

  always_comb begin
    case (md_op)
      MD_MFHI: ex_res = hi_nxt;
      MD_MFLO: ex_res = lo_nxt;
      MD_MT:   ex_res = 32'd0;
      default: ex_res = alu_res;
    endcase
  end

  // EX/MEM register boundary, HI/LO and md control
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_out   <= 32'd0;
      data_b0   <= 32'd0;
      pc_m      <= 32'd0;
      reg_wr_m  <= 1'b0;
      mem_rd_m  <= 1'b0;
      mem_wr_m  <= 1'b0;
      mem2reg_m <= 2'd0;
      addrc_m   <= 5'd0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      md_busy   <= 1'b0;
      md_cnt    <= 5'd0;
    end else begin
      hi   <= hi_nxt;
      lo   <= lo_nxt;
      pc_m <= pc;
      if (flush || ex_stall) begin
        reg_wr_m  <= 1'b0;
        mem_rd_m  <= 1'b0;
        mem_wr_m  <= 1'b0;
        mem2reg_m <= 2'd0;
        addrc_m   <= 5'd0;
      end else begin
        alu_out   <= ex_res;
        data_b0   <= fwd_b_val;
        reg_wr_m  <= reg_wr;
        mem_rd_m  <= mem_rd;
        mem_wr_m  <= mem_wr;
        mem2reg_m <= mem2reg;
        addrc_m   <= addrc;
      end
      if (md_start) begin
        md_busy <= 1'b1;
        md_cnt  <= 5'd0;
      end else if (md_busy) begin
        md_cnt <= md_cnt + 5'd1;
        if (md_done) md_busy <= 1'b0;
      end
    end
  end

  // md datapath registers; only meaningful while md_busy is high
  always_ff @(posedge clk) begin
    if (md_start) begin
      md_acc   <= 32'd0;
      md_q     <= abs32(op_a, md_sgn);
      md_opnd  <= abs32(op_b, md_sgn);
      md_dvd   <= op_a;
      md_div   <= (md_op == MD_DIV) || (md_op == MD_DIVU);
      md_neg_q <= md_sgn && (op_a[31] ^ op_b[31]);
      md_neg_r <= md_sgn && op_a[31];
    end else if (md_busy) begin
      md_acc <= step_acc;
      md_q   <= step_q;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: ALU vector table, hand-written multi-cycle sequences and a
// randomized run, all checked against an arithmetic reference model.
module tb_ex_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] data_a, data_b, imm, wb_data, pc;
  logic [4:0]  shamt, addrc;
  logic        alusrc_b, sh_var, md_hi, reg_wr, mem_rd, mem_wr, flush;
  logic [3:0]  alu_fun;
  logic [2:0]  md_op;
  logic [1:0]  fwd_a, fwd_b, mem2reg;
  logic [31:0] alu_out, data_b0, pc_m;
  logic        reg_wr_m, mem_rd_m, mem_wr_m, ex_stall, md_busy;
  logic [1:0]  mem2reg_m;
  logic [4:0]  addrc_m;
  logic [9:0]  ctrl_m;

  assign ctrl_m = {reg_wr_m, mem_rd_m, mem_wr_m, mem2reg_m, addrc_m};

  ex_stage dut (
    .clk(clk), .reset(reset), .data_a(data_a), .data_b(data_b), .imm(imm),
    .shamt(shamt), .alusrc_b(alusrc_b), .sh_var(sh_var), .alu_fun(alu_fun),
    .md_op(md_op), .md_hi(md_hi), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .wb_data(wb_data), .pc(pc), .reg_wr(reg_wr), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem2reg(mem2reg), .addrc(addrc), .flush(flush),
    .alu_out(alu_out), .data_b0(data_b0), .pc_m(pc_m), .reg_wr_m(reg_wr_m),
    .mem_rd_m(mem_rd_m), .mem_wr_m(mem_wr_m), .mem2reg_m(mem2reg_m),
    .addrc_m(addrc_m), .ex_stall(ex_stall), .md_busy(md_busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] m_alu, m_b0, m_pc, m_hi, m_lo, p_hi, p_lo;
  logic [9:0]  m_ctrl;
  logic        m_busy;
  int          m_left;

  typedef struct {
    logic [3:0]  fun;
    logic [31:0] a, b, im;
    logic [4:0]  sa;
    logic        src, shv;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[$];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] f, input logic [31:0] a,
                                          input logic [31:0] b, input int sa);
    int sa_i, sb_i;
    longint ext;
    sa_i = a; sb_i = b;
    case (f)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return (sa_i < sb_i) ? 32'd1 : 32'd0;
      4'd7:  return (a < b) ? 32'd1 : 32'd0;
      4'd8:  return b * (32'd1 << sa);
      4'd9:  return b / (32'd1 << sa);
      4'd10: begin ext = sb_i; ext = ext >>> sa; return ext[31:0]; end
      4'd11: return b * 32'h0001_0000;
      default: return 32'd0;
    endcase
  endfunction

  task automatic md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    int ia, ib;
    ia = a; ib = b;
    sa = ia; sb = ib;
    ua = {32'd0, a}; ub = {32'd0, b};
    hi = 32'd0; lo = 32'd0;
    case (op)
      3'd1: begin q = sa * sb; hi = q[63:32]; lo = q[31:0]; end
      3'd2: begin uq = ua * ub; hi = uq[63:32]; lo = uq[31:0]; end
      3'd3: if (b == 32'd0) begin hi = a; lo = 32'hFFFF_FFFF; end
            else begin q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0]; end
      3'd4: if (b == 32'd0) begin hi = a; lo = 32'hFFFF_FFFF; end
            else begin uq = ua / ub; ur = ua % ub; hi = ur[31:0]; lo = uq[31:0]; end
      default: ;
    endcase
  endtask

  function automatic logic [31:0] fsel(input logic [1:0] s, input logic [31:0] idv);
    case (s)
      2'd0:    return idv;
      2'd1:    return m_alu;
      2'd2:    return wb_data;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_alu = 0; m_b0 = 0; m_pc = 0; m_hi = 0; m_lo = 0; m_ctrl = 0;
    m_busy = 0; m_left = 0; p_hi = 0; p_lo = 0;
  endtask

  task automatic idle();
    data_a = 0; data_b = 0; imm = 0; wb_data = 0; shamt = 0; addrc = 0;
    alusrc_b = 0; sh_var = 0; md_hi = 0; reg_wr = 0; mem_rd = 0; mem_wr = 0;
    flush = 0; alu_fun = 0; md_op = 0; fwd_a = 0; fwd_b = 0; mem2reg = 0;
  endtask

  // One clock: predict, clock, compare every EX/MEM output and md_busy.
  task automatic tick();
    logic [31:0] a, bf, b, res;
    logic        stall;
    int          sa;
    #1;
    a     = fsel(fwd_a, data_a);
    bf    = fsel(fwd_b, data_b);
    b     = alusrc_b ? imm : bf;
    sa    = sh_var ? int'(a[4:0]) : int'(shamt);
    stall = m_busy && (md_op != 3'd0);
    chk("ex_stall", {31'd0, ex_stall}, {31'd0, stall});
    case (md_op)
      3'd5:    res = m_hi;
      3'd6:    res = m_lo;
      3'd7:    res = 32'd0;
      default: res = ref_alu(alu_fun, a, b, sa);
    endcase
    @(posedge clk);
    m_pc = pc;
    if (flush || stall) m_ctrl = 10'd0;
    else begin
      m_alu  = res;
      m_b0   = bf;
      m_ctrl = {reg_wr, mem_rd, mem_wr, mem2reg, addrc};
    end
    if (m_busy) begin
      m_left--;
      if (m_left == 0) begin m_busy = 0; m_hi = p_hi; m_lo = p_lo; end
    end else if (!flush) begin
      if (md_op >= 3'd1 && md_op <= 3'd4) begin
        md_ref(md_op, a, b, p_hi, p_lo);
        m_busy = 1; m_left = 32;
      end else if (md_op == 3'd7) begin
        if (md_hi) m_hi = a; else m_lo = a;
      end
    end
    #1;
    chk("alu_out", alu_out, m_alu);
    chk("data_b0", data_b0, m_b0);
    chk("pc_m", pc_m, m_pc);
    chk("ctrl_m", {22'd0, ctrl_m}, {22'd0, m_ctrl});
    chk("md_busy", {31'd0, md_busy}, {31'd0, m_busy});
  endtask

  task automatic md_run(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    idle(); md_op = op; data_a = a; data_b = b; tick();
    idle(); n = 0;
    while (md_busy && n < 40) begin tick(); n++; end
    chk({nm, "_busy_cycles"}, n, 32);
    idle(); md_op = 3'd6; tick(); chk({nm, "_lo"}, alu_out, elo);
    idle(); md_op = 3'd5; tick(); chk({nm, "_hi"}, alu_out, ehi);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_alu_out"}, alu_out, 0);
    chk({nm, "_data_b0"}, data_b0, 0);
    chk({nm, "_pc_m"}, pc_m, 0);
    chk({nm, "_ctrl_m"}, {22'd0, ctrl_m}, 0);
    chk({nm, "_md_busy"}, {31'd0, md_busy}, 0);
  endtask

  initial begin
    int n, r;
    reset = 1'b0; idle(); pc = 0; model_reset();
    #12;
    chk_all_zero("reset");
    chk("reset_ex_stall", {31'd0, ex_stall}, 0);
    @(negedge clk); reset = 1'b1;

    //            fun    a             b             imm           sa  src shv  expected
    vt.push_back('{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h0,        0,  0,  0, 32'h80000000});
    vt.push_back('{4'd10, 32'h0,        32'h80000000, 32'h0,        4,  0,  0, 32'hF8000000});
    vt.push_back('{4'd6,  32'hFFFFFFFF, 32'h00000001, 32'h0,        0,  0,  0, 32'h00000001});
    vt.push_back('{4'd7,  32'hFFFFFFFF, 32'h00000001, 32'h0,        0,  0,  0, 32'h00000000});
    vt.push_back('{4'd1,  32'h00000000, 32'h00000001, 32'h0,        0,  0,  0, 32'hFFFFFFFF});
    vt.push_back('{4'd2,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        0,  0,  0, 32'h00F000F0});
    vt.push_back('{4'd3,  32'h12340000, 32'h00005678, 32'h0,        0,  0,  0, 32'h12345678});
    vt.push_back('{4'd4,  32'hFFFF0000, 32'h0F0F0F0F, 32'h0,        0,  0,  0, 32'hF0F00F0F});
    vt.push_back('{4'd5,  32'h00000000, 32'h00000000, 32'h0,        0,  0,  0, 32'hFFFFFFFF});
    vt.push_back('{4'd8,  32'h0000001F, 32'h00000001, 32'h0,        3,  0,  1, 32'h80000000});
    vt.push_back('{4'd9,  32'h0,        32'h80000000, 32'h0,       31,  0,  0, 32'h00000001});
    vt.push_back('{4'd11, 32'h0,        32'h12345678, 32'h0000ABCD, 0,  1,  0, 32'hABCD0000});
    vt.push_back('{4'd12, 32'h5,        32'h5,        32'h0,        0,  0,  0, 32'h00000000});
    vt.push_back('{4'd0,  32'h00000010, 32'h0,        32'hFFFFFFFF, 0,  1,  0, 32'h0000000F});
    vt.push_back('{4'd10, 32'h0,        32'h7FFFFFFF, 32'h0,        8,  0,  0, 32'h007FFFFF});

    foreach (vt[i]) begin
      idle();
      alu_fun = vt[i].fun; data_a = vt[i].a; data_b = vt[i].b; imm = vt[i].im;
      shamt = vt[i].sa; alusrc_b = vt[i].src; sh_var = vt[i].shv;
      pc = 32'h400 + 32'(i * 4); reg_wr = 1; addrc = 5'(i);
      tick();
      chk($sformatf("alu_vec%0d", i), alu_out, vt[i].exp);
    end

    // forwarding from EX/MEM and WB
    idle(); data_b = 32'h10; tick(); chk("fwd_seed", alu_out, 32'h10);
    idle(); fwd_a = 1; alusrc_b = 1; imm = 4; tick(); chk("fwd_a_exmem", alu_out, 32'h14);
    idle(); fwd_b = 2; wb_data = 32'hCAFEF00D; alusrc_b = 1; imm = 8; mem_wr = 1; tick();
    chk("fwd_b_wb_store", data_b0, 32'hCAFEF00D);
    chk("fwd_b_store_addr", alu_out, 32'h8);

    // MULT followed at once by MFLO: stalled for the full operation
    idle(); md_op = 3'd1; data_a = 32'hFFFFFFFE; data_b = 3; tick();
    idle(); md_op = 3'd6; reg_wr = 1; addrc = 5'd8; n = 0;
    while (n < 40) begin
      #1;
      if (!ex_stall) break;
      n++;
      tick();
    end
    chk("mult_mflo_stall_cycles", n, 32);
    tick();
    chk("mult_mflo_lo", alu_out, 32'hFFFFFFFA);
    chk("mult_mflo_ctrl", {22'd0, ctrl_m}, {22'd0, 10'b1_0_0_00_01000});
    idle(); md_op = 3'd5; tick(); chk("mult_hi", alu_out, 32'hFFFFFFFF);

    md_run("div_neg",   3'd3, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    md_run("divu_zero", 3'd4, 32'h5,        32'h0,        32'h00000005, 32'hFFFFFFFF);
    md_run("div_ovf",   3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    md_run("multu_max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);

    // MTHI/MTLO and flush behaviour
    idle(); md_op = 3'd7; md_hi = 1; data_a = 32'h11111111; tick();
    idle(); md_op = 3'd7; md_hi = 0; data_a = 32'h5555AAAA; tick();
    idle(); md_op = 3'd7; md_hi = 1; data_a = 32'h22222222; flush = 1; tick();
    idle(); md_op = 3'd5; tick(); chk("mthi_flushed_hi", alu_out, 32'h11111111);
    idle(); md_op = 3'd6; tick(); chk("mtlo_lo", alu_out, 32'h5555AAAA);
    idle(); reg_wr = 1; mem_wr = 1; addrc = 5'd3; flush = 1; pc = 32'h500; tick();
    chk("flush_reg_wr_m", {31'd0, reg_wr_m}, 0);
    chk("flush_mem_wr_m", {31'd0, mem_wr_m}, 0);
    chk("flush_pc_m", pc_m, 32'h500);
    idle(); md_op = 3'd3; data_a = 100; data_b = 7; flush = 1; tick();
    chk("div_flushed_busy", {31'd0, md_busy}, 0);

    // asynchronous reset in the middle of a MULTU
    idle(); md_op = 3'd2; data_a = 32'hFFFFFFFF; data_b = 32'hFFFFFFFF; tick();
    idle(); data_a = 1; reg_wr = 1; mem_rd = 1; addrc = 5'd9; pc = 32'h1000;
    repeat (9) tick();
    chk("pre_reset_busy", {31'd0, md_busy}, 1);
    #2; reset = 1'b0; #1;
    chk_all_zero("async_reset");
    model_reset();
    @(negedge clk); reset = 1'b1;
    idle(); pc = 0; md_op = 3'd5; tick(); chk("post_reset_hi", alu_out, 0);
    idle(); md_op = 3'd6; tick(); chk("post_reset_lo", alu_out, 0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      data_a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      data_b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      imm      = $urandom;
      wb_data  = $urandom;
      pc       = $urandom;
      shamt    = 5'($urandom_range(0, 31));
      addrc    = 5'($urandom_range(0, 31));
      mem2reg  = 2'($urandom_range(0, 3));
      alusrc_b = 1'($urandom_range(0, 1));
      sh_var   = 1'($urandom_range(0, 1));
      md_hi    = 1'($urandom_range(0, 1));
      reg_wr   = 1'($urandom_range(0, 1));
      mem_rd   = 1'($urandom_range(0, 1));
      mem_wr   = 1'($urandom_range(0, 1));
      alu_fun  = 4'($urandom_range(0, 15));
      fwd_a    = 2'($urandom_range(0, 3));
      fwd_b    = 2'($urandom_range(0, 3));
      flush    = ($urandom_range(0, 7) == 0);
      r = $urandom_range(0, 19);
      md_op = (r == 0) ? 3'($urandom_range(1, 4)) : (r == 1) ? 3'd5 :
              (r == 2) ? 3'd6 : (r == 3) ? 3'd7 : 3'd0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
